// File: rtl/matmul_out_quantizer_pkg.sv
// Shared sizes and types for the matmul accumulator readout/quantizer slice.
package matmul_pkg;
  localparam int N_WORDS    = 256;
  localparam int ADDR_W     = $clog2(N_WORDS);
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} matq_state_t;
  typedef logic signed [OUT_W-1:0] q_elem_t;
endpackage

// File: rtl/matmul_out_quantizer_if.sv
// Packed-pair output stream (valid/ready) from the quantizer toward host/DMA.
interface matq_stream_if;
  import matmul_pkg::*;

  logic               valid;
  logic               ready;
  logic [2*OUT_W-1:0] data;
  logic               last;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/matmul_out_quantizer_round_sat.sv
// Combinational round-half-up, arithmetic right shift by fl, saturate to OUT_W.
// The sat_flag port exists only when MATQ_SAT_CNT_EN is defined.
module matq_round_sat
  import matmul_pkg::*;
(
  input  logic [ACC_W-1:0] x,
  input  logic [2:0]       fl,
  output q_elem_t          y
`ifdef MATQ_SAT_CNT_EN
  ,
  output logic             sat_flag
`endif
);
  logic signed [ACC_W:0]         ext;
  logic signed [ACC_W:0]         half;
  logic signed [ACC_W:0]         rnd;
  logic signed [ACC_W:0]         shf;
  logic        [ACC_W-OUT_W+1:0] upper;
  logic                          clamp;

  always_comb begin
    ext  = $signed({x[ACC_W-1], x});
    half = '0;
    if (fl != 3'd0) half = (ACC_W+1)'(1) << (fl - 3'd1);
    // one guard bit keeps x + half from wrapping at the positive limit
    rnd   = ext + half;
    shf   = rnd >>> fl;
    upper = shf[ACC_W:OUT_W-1];
    clamp = !((&upper) || !(|upper));
    if (!clamp)         y = shf[OUT_W-1:0];
    else if (shf[ACC_W]) y = {1'b1, {(OUT_W-1){1'b0}}};
    else                 y = {1'b0, {(OUT_W-1){1'b1}}};
  end

`ifdef MATQ_SAT_CNT_EN
  assign sat_flag = clamp;
`endif
endmodule

// File: rtl/matmul_out_quantizer.sv
// Scans the accumulator SRAM after done, quantizes each entry and streams pairs out.
// Optional MATQ_SAT_CNT_EN adds o_sat_cnt (elements clamped in the current run).
module matmul_out_quantizer
  import matmul_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [2:0]        i_fl,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_omem_cen,
  output logic [ADDR_W-1:0] o_omem_addr,
  input  logic [ACC_W-1:0]  i_omem_dout,
`ifdef MATQ_SAT_CNT_EN
  output logic [ADDR_W:0]   o_sat_cnt,
`endif
  matq_stream_if.master     strm
);
  matq_state_t       state, state_nxt;
  logic [2:0]        fl_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  q_elem_t           fifo_mem [FIFO_DEPTH];
  logic [1:0]        rd_ptr, wr_ptr;
  logic [2:0]        fifo_cnt;
  logic [ADDR_W-2:0] word_cnt;
  logic              issue, start_ok, hs, last_word, credit;
  q_elem_t           q_val;
`ifdef MATQ_SAT_CNT_EN
  logic              q_sat;
`endif

  matq_round_sat u_round_sat (
    .x        (i_omem_dout),
    .fl       (fl_q),
    .y        (q_val)
`ifdef MATQ_SAT_CNT_EN
    ,
    .sat_flag (q_sat)
`endif
  );

  // Credit uses registered occupancy only, so i_ready never reaches the SRAM enable.
  assign credit      = (fifo_cnt + 3'(inflight_q)) < 3'(FIFO_DEPTH);
  assign strm.valid  = fifo_cnt >= 3'd2;
  assign strm.data   = {fifo_mem[rd_ptr + 2'd1], fifo_mem[rd_ptr]};
  assign last_word   = word_cnt == (ADDR_W-1)'(N_WORDS/2 - 1);
  assign strm.last   = strm.valid && last_word;
  assign hs          = strm.valid && strm.ready;
  assign o_omem_addr = addr_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    start_ok   = 1'b0;
    o_omem_cen = 1'b1;
    o_done     = 1'b0;
    o_busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (i_start) begin
          start_ok  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (credit) begin
          issue      = 1'b1;
          o_omem_cen = 1'b0;
          if (addr_q == ADDR_W'(N_WORDS - 1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (hs && last_word) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      fl_q       <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      fifo_mem   <= '{default: '0};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_cnt   <= '0;
      word_cnt   <= '0;
    end else begin
      if (start_ok) begin
        fl_q     <= i_fl;
        addr_q   <= '0;
        word_cnt <= '0;
      end
      if (issue) addr_q <= addr_q + 1'b1;
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_mem[wr_ptr] <= q_val;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (hs) begin
        rd_ptr   <= rd_ptr + 2'd2;
        word_cnt <= word_cnt + 1'b1;
      end
      fifo_cnt <= fifo_cnt + 3'(inflight_q) - (hs ? 3'd2 : 3'd0);
    end
  end

`ifdef MATQ_SAT_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      o_sat_cnt <= '0;
    else if (start_ok)
      o_sat_cnt <= '0;
    else if (inflight_q && q_sat && o_sat_cnt != (ADDR_W+1)'(N_WORDS))
      o_sat_cnt <= o_sat_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_matmul_out_quantizer.sv
// Randomized bench for matmul_out_quantizer against a floor-division reference model.
module tb_matmul_out_quantizer;
  import matmul_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [2:0]        fl_in;
  logic              busy, done, cen;
  logic [ADDR_W-1:0] addr;
  logic [ACC_W-1:0]  dout;
`ifdef MATQ_SAT_CNT_EN
  logic [ADDR_W:0]   sat_cnt;
`endif

  matq_stream_if strm();

  matmul_out_quantizer dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .i_fl        (fl_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_omem_cen  (cen),
    .o_omem_addr (addr),
    .i_omem_dout (dout),
`ifdef MATQ_SAT_CNT_EN
    .o_sat_cnt   (sat_cnt),
`endif
    .strm        (strm)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [N_WORDS];
  always @(posedge clk) dout <= !cen ? mem[addr] : $urandom;

  logic [31:0] exp_q[$];
  logic [31:0] w, prev_data, got0, got_last;
  int          n_issued, n_acc, n_done, exp_sat;
  int          n_chk = 0, n_pass = 0;
  bit          mon_en = 0, exp_busy = 0, pend_done = 0, prev_stall = 0, rand_ready = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp_v);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  // Reference: y = floor((x + 2^(fl-1)) / 2^fl), clamped to int16.
  function automatic void quant(input logic [31:0] raw, input int fl,
                                output logic [15:0] q, output bit sat);
    longint x, d, y;
    x = longint'($signed(raw));
    d = longint'(1) << fl;
    y = x + d / 2;
    y = (y >= 0) ? y / d : -((-y + d - 1) / d);
    sat = 1'b1;
    if (y > 32767)       y = 32767;
    else if (y < -32768) y = -32768;
    else                 sat = 1'b0;
    q = y[15:0];
  endfunction

  initial begin
    strm.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      strm.ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (prev_stall)
      chk(strm.valid && strm.data == prev_data, "stall_hold", strm.data, prev_data);
    prev_stall = strm.valid && !strm.ready;
    prev_data  = strm.data;
    chk(busy == exp_busy, "busy", busy, exp_busy);
    if (!cen) begin
      chk(n_issued < N_WORDS && addr == n_issued[ADDR_W-1:0], "rd_addr", addr, n_issued);
      chk(n_issued - 2 * n_acc < FIFO_DEPTH, "credit", n_issued - 2 * n_acc, FIFO_DEPTH - 1);
      n_issued++;
    end
    if (strm.valid)
      chk(strm.last == (n_acc == N_WORDS/2 - 1), "last", strm.last, n_acc == N_WORDS/2 - 1);
    chk(done == pend_done, "done_pulse", done, pend_done);
    if (done) begin
      exp_busy = 1'b0;
      n_done++;
    end
    pend_done = 1'b0;
    if (strm.valid && strm.ready) begin
      chk(exp_q.size() != 0, "extra_word", strm.data, 0);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk(strm.data == w, "data", strm.data, w);
      end
      if (n_acc == 0) got0 = strm.data;
      if (n_acc == N_WORDS/2 - 1) begin
        got_last  = strm.data;
        pend_done = 1'b1;
      end
      n_acc++;
    end
  end

  task automatic check_idle(input string name);
    chk(busy == 1'b0 && done == 1'b0 && cen == 1'b1 && addr == '0, {name, "_ctl"},
        {busy, done, cen, addr}, {3'b001, 8'h00});
    chk(strm.valid == 1'b0 && strm.last == 1'b0 && strm.data == '0, {name, "_strm"},
        {strm.valid, strm.last, strm.data}, 0);
`ifdef MATQ_SAT_CNT_EN
    chk(sat_cnt == '0, {name, "_satcnt"}, sat_cnt, 0);
`endif
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N_WORDS; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? $urandom
             : 32'($signed($urandom_range(0, 2097151)) - 1048576);
  endtask

  task automatic do_run(input int fl, input bit rr, input bit abort40, input bit dup,
                        input bit chk_lat);
    logic [15:0] lo, hi;
    bit s0, s1, dup_sent, fin;
    int lat;
    exp_q.delete();
    exp_sat = 0;
    for (int k = 0; k < N_WORDS/2; k++) begin
      quant(mem[2*k], fl, lo, s0);
      quant(mem[2*k+1], fl, hi, s1);
      exp_q.push_back({hi, lo});
      exp_sat += int'(s0) + int'(s1);
    end
    n_issued = 0; n_acc = 0; n_done = 0;
    pend_done = 1'b0; prev_stall = 1'b0; dup_sent = 1'b0; fin = 1'b0;
    rand_ready = rr;
    mon_en = 1'b1;
    start = 1'b1;
    fl_in = fl[2:0];
    @(posedge clk); #1;
    start = 1'b0;
    fl_in = 3'($urandom);
    exp_busy = 1'b1;
    if (chk_lat) begin
      lat = 0;
      while (!strm.valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk(lat == 3, "first_valid_lat", lat, 3);
    end
    for (int c = 0; c < 6000 && !fin; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dup && !dup_sent && n_acc >= 20) begin
        start    = 1'b1;
        fl_in    = 3'd7;
        dup_sent = 1'b1;
      end
      if (abort40 && n_acc >= 40) begin
        mon_en = 1'b0;
        rstn   = 1'b0;
        @(posedge clk); #1;
        check_idle("mid_rst");
        rstn       = 1'b1;
        exp_busy   = 1'b0;
        rand_ready = 1'b0;
        return;
      end
      if (n_done > 0) fin = 1'b1;
    end
    chk(fin, "run_timeout", n_acc, N_WORDS/2);
    repeat (4) @(posedge clk);
    #1;
    chk(n_done == 1, "done_count", n_done, 1);
    chk(n_issued == N_WORDS, "reads_total", n_issued, N_WORDS);
    chk(n_acc == N_WORDS/2, "words_total", n_acc, N_WORDS/2);
    chk(busy == 1'b0, "busy_after", busy, 0);
`ifdef MATQ_SAT_CNT_EN
    chk(sat_cnt == (ADDR_W+1)'(exp_sat), "sat_cnt", sat_cnt, exp_sat);
`endif
    mon_en = 1'b0;
    rand_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; fl_in = '0;
    for (int i = 0; i < N_WORDS; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < N_WORDS; i++) mem[i] = 32'(i);
    do_run(0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk(got0 == 32'h0001_0000, "ramp_word0", got0, 32'h0001_0000);
    chk(got_last == 32'h00FF_00FE, "ramp_word127", got_last, 32'h00FF_00FE);

    fill_rand();
    mem[0] = 32'h0000_0003;
    mem[1] = 32'hFFFF_FFFD;
    do_run(1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(got0 == 32'hFFFF_0002, "round_word0", got0, 32'hFFFF_0002);

    fill_rand();
    mem[0] = 32'h0001_0000;
    mem[1] = 32'h8000_0000;
    do_run(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk(got0 == 32'h8000_7FFF, "sat_word0", got0, 32'h8000_7FFF);
`ifdef MATQ_SAT_CNT_EN
    chk(sat_cnt >= 2, "sat_cnt_min", sat_cnt, 2);
`endif

    for (int i = 0; i < N_WORDS; i++) mem[i] = 32'(i);
    do_run(0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk(got_last == 32'h00FF_00FE, "ramp_stall_word127", got_last, 32'h00FF_00FE);

    fill_rand();
    do_run(3, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    fill_rand();
    do_run(2, 1'b0, 1'b0, 1'b0, 1'b1);

    fill_rand();
    do_run(3, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int f = 4; f < 8; f++) begin
      fill_rand();
      do_run(f, f[0], 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/matmul_out_quantizer.md
Name: matmul_out_quantizer

Overview:
Downstream readout stage of the 16x16 matmul engine. After the engine asserts done, it scans the 256-entry 32-bit accumulator SRAM (OMEM-style port, 1-cycle read latency). Each accumulator is rounded and right-shifted by the fractional length, then saturated to 16 bits. Results are packed two per 32-bit word and streamed out over a valid/ready interface toward the host/DMA.

Parameters:
N_WORDS, 256, accumulator entries to scan (even, power of 2)
ADDR_W, 8, SRAM address width = log2(N_WORDS)
ACC_W, 32, accumulator width
OUT_W, 16, quantized element width (output word = 2*OUT_W)

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rstn  input  1  reset, synchronous, active-low
i_start  input  1  single-cycle start pulse; ignored while busy
i_fl  input  3  fractional shift 0..7, sampled on accepted start
o_busy  output  1  high from accepted start until done pulse (inclusive)
o_done  output  1  one-cycle pulse after final output handshake
o_omem_cen  output  1  SRAM chip enable, active-low (0 = read issued)
o_omem_addr  output  ADDR_W  SRAM read address
i_omem_dout  input  ACC_W  SRAM read data, valid cycle after cen=0
o_valid  output  1  output word valid
i_ready  input  1  downstream accept
o_data  output  2*OUT_W  {q[2k+1], q[2k]}
o_last  output  1  high with final word (k = N_WORDS/2-1)

Behaviour:
- Reset (i_rstn=0 at edge): state IDLE; o_busy=0, o_done=0, o_omem_cen=1, o_omem_addr=0, o_valid=0, o_data=0, o_last=0. Internal FIFO, counters, fl register cleared. Applies mid-operation; any in-flight read is discarded.
- FSM states:
  - IDLE: on i_start, latch i_fl, clear counters, go to RUN.
  - RUN: issue reads at addr 0..N_WORDS-1 ascending.
  - DRAIN: all reads issued; wait until every element is emitted.
  - DONE: single cycle, o_done=1, then IDLE.
- Read issue: in RUN, o_omem_cen=0 in a cycle only if fifo_count + inflight < 4 (4-entry x OUT_W element FIFO; inflight ≤ 1). Address increments on each issue. After issuing N_WORDS-1, go to DRAIN.
- Data capture: the cycle after cen=0, the quantized i_omem_dout is pushed into the FIFO. No overflow is possible by the credit rule.
- Quantize, signed: if fl=0, y=x. Else y = (x + 2^(fl-1)) >>> fl, computed in ACC_W+1 bits (round half up, no wrap at +max). Saturate to [-32768, 32767].
- Output: o_valid=1 whenever fifo_count ≥ 2, with o_data = {second, first} (older element in low half). Handshake (o_valid & i_ready) pops 2. o_data/o_valid hold stable while i_ready=0. No combinational path from i_ready to o_omem_cen beyond the credit compare.
- Throughput: 1 output word per 2 cycles when i_ready is held high (read-limited). First o_valid occurs 3 cycles after start.
- o_last asserted with word N_WORDS/2-1 only. o_done fires the cycle after that handshake; o_busy drops with it.
- i_start while busy: ignored; i_fl change while busy: no effect.

Optional Feature:
MATQ_SAT_CNT_EN
- Defined: adds output port o_sat_cnt [ADDR_W:0], a count of elements clamped by saturation in the current run. Cleared on accepted start, saturates at N_WORDS, held after done, 0 on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package matmul_pkg: ACC_W, OUT_W, N_WORDS, ADDR_W localparams; typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} matq_state_t; typedef logic signed [OUT_W-1:0] q_elem_t.
- Sub-module matq_round_sat: purely combinational round/shift/saturate (x, fl -> y, sat_flag), instantiated once on the SRAM data path.

Test Plan:
- SRAM model with mem[i]=i, fl=0, i_ready=1 -> 128 words, word k = {2k+1, 2k}. o_last on k=127, o_done one cycle later, 256 reads total.
- mem[0]=0x00000003, mem[1]=0xFFFFFFFD, fl=1 -> word0 = {0xFFFF, 0x0002}, i.e. -3 rounds to -1, +3 rounds to +2.
- mem[0]=0x00010000, mem[1]=0x80000000, fl=0 -> word0 = {0x8000, 0x7FFF}. With MATQ_SAT_CNT_EN, o_sat_cnt ≥ 2.
- i_ready randomly toggled at 30% duty -> identical data sequence to the ready=1 run; o_data stable while stalled; FIFO never exceeds 4; cen never issued when count+inflight=4.
- i_rstn=0 for one cycle after 40 output words -> next cycle all outputs 0, IDLE. A new start with fl=2 restarts from addr 0 with shift 2.
- Second i_start pulse mid-run with i_fl=7 -> ignored; results remain quantized with the original fl, exactly one o_done.
